fpga_cfg_sequencer: RTL and testbench



---
 rtl/fpga_cfg_sequencer.sv | 124 ++++++++++++
 tb/tb_fpga_cfg_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_cfg_sequencer.sv
// fpga_cfg_sequencer: streams the bitstream LSB-first into the fabric, then waits
// for cfg_ready before enabling run, flagging a sticky error on timeout.
module fpga_cfg_sequencer #(
    parameter int BITSTREAM_LENGTH = 1024,
    parameter int TIMEOUT_CYCLES   = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] host_tdata,
    input  logic       host_tvalid,
    output logic       host_tready,
    output logic       cfg,
    output logic       cfg_tdata,
    output logic       cfg_tvalid,
    input  logic       cfg_tready,
    input  logic       cfg_ready,
    output logic       run,
    output logic       busy,
    output logic       error
);
    localparam int BW = $clog2(BITSTREAM_LENGTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BW-1:0] B_LEN  = BW'(BITSTREAM_LENGTH);
    localparam logic [BW-1:0] B_LAST = BW'(BITSTREAM_LENGTH - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_READY, RUN, ERR} state_t;

    state_t          state;
    logic [7:0]      data_buf;
    logic            buf_valid;
    logic [2:0]      bit_idx;
    logic [BW-1:0]   bits_sent;
    logic [TW-1:0]   tcnt;

    assign host_tready = state == LOAD && !buf_valid && bits_sent < B_LEN;
    assign cfg_tvalid  = state == LOAD && buf_valid;
    assign cfg_tdata   = data_buf[bit_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cfg       <= 1'b0;
            run       <= 1'b0;
            busy      <= 1'b0;
            error     <= 1'b0;
            data_buf  <= '0;
            buf_valid <= 1'b0;
            bit_idx   <= '0;
            bits_sent <= '0;
            tcnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bits_sent <= '0;
                    buf_valid <= 1'b0;
                    if (start) begin
                        state <= LOAD;
                        cfg   <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (host_tvalid && host_tready) begin
                        data_buf  <= host_tdata;
                        buf_valid <= 1'b1;
                        bit_idx   <= '0;
                    end
                    // The last bit may land mid-byte; its unsent upper bits are dropped.
                    if (cfg_tvalid && cfg_tready) begin
                        bit_idx   <= bit_idx + 3'd1;
                        bits_sent <= bits_sent + 1'b1;
                        if (bit_idx == 3'd7 || bits_sent == B_LAST)
                            buf_valid <= 1'b0;
                        if (bits_sent == B_LAST) begin
                            state <= WAIT_READY;
                            tcnt  <= '0;
                        end
                    end
                end
                WAIT_READY: begin
                    tcnt <= tcnt + 1'b1;
                    if (cfg_ready) begin
                        state <= RUN;
                        cfg   <= 1'b0;
                        busy  <= 1'b0;
                        run   <= 1'b1;
                    end else if (tcnt == T_LAST) begin
                        state <= ERR;
                        cfg   <= 1'b0;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end
                end
                RUN: begin
                    if (start) begin
                        state     <= LOAD;
                        run       <= 1'b0;
                        cfg       <= 1'b1;
                        busy      <= 1'b1;
                        bits_sent <= '0;
                        buf_valid <= 1'b0;
                    end else if (stop) begin
                        state <= IDLE;
                        run   <= 1'b0;
                    end
                end
                ERR: begin
                    if (start) begin
                        state     <= LOAD;
                        error     <= 1'b0;
                        cfg       <= 1'b1;
                        busy      <= 1'b1;
                        bits_sent <= '0;
                        buf_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpga_cfg_sequencer.sv
// tb_fpga_cfg_sequencer: directed vectors for load, backpressure, timeout and run control.
module tb_fpga_cfg_sequencer;
    localparam int LEN = 20;
    localparam int TO  = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] host_tdata = 8'h00;
    logic       host_tvalid = 1'b0;
    logic       host_tready;
    logic       cfg;
    logic       cfg_tdata;
    logic       cfg_tvalid;
    logic       cfg_tready = 1'b0;
    logic       cfg_ready = 1'b0;
    logic       run;
    logic       busy;
    logic       error;

    fpga_cfg_sequencer #(.BITSTREAM_LENGTH(LEN), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .host_tdata(host_tdata), .host_tvalid(host_tvalid), .host_tready(host_tready),
        .cfg(cfg), .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready),
        .cfg_ready(cfg_ready), .run(run), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       start;
        logic       stop;
        logic       rdy;
        logic [4:0] exp;
    } vec_t;

    vec_t        tbl [7];
    logic [7:0]  src [3];
    logic [19:0] exp_bits;
    logic [19:0] got_bits;
    int          checks = 0;
    int          errors = 0;
    int          hidx;
    int          hs;
    int          got;
    int          cyc;
    int          n;
    logic        held = 1'b0;
    logic        held_bit = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_host();
        host_tdata = hidx < 3 ? src[hidx] : 8'hFF;
    endtask

    task automatic step();
        logic hfire;
        @(negedge clk);
        hfire = host_tvalid && host_tready;
        if (held) begin
            chk("hold_valid", 32'(cfg_tvalid), 32'd1);
            chk("hold_data", 32'(cfg_tdata), 32'(held_bit));
        end
        if (cfg_tvalid && cfg_tready) begin
            if (got < LEN) got_bits[got] = cfg_tdata;
            got++;
            held = 1'b0;
        end else begin
            held     = cfg_tvalid;
            held_bit = cfg_tdata;
        end
        if (hfire) hs++;
        @(posedge clk);
        #1;
        if (hfire) begin
            hidx++;
            drive_host();
        end
    endtask

    task automatic run_load(input logic [3:0] pat, input int target, output int cycles);
        got = 0;
        hs = 0;
        hidx = 0;
        held = 1'b0;
        got_bits = '0;
        drive_host();
        host_tvalid = 1'b1;
        cycles = 0;
        while (got < target && cycles < 200) begin
            cfg_tready = pat[cycles % 4];
            step();
            cycles++;
        end
        host_tvalid = 1'b0;
        cfg_tready = 1'b0;
        chk("load_bits_count", 32'(got), 32'(target));
    endtask

    task automatic check_bits(input string tag);
        for (int i = 0; i < LEN; i++)
            chk($sformatf("%s_bit%0d", tag, i), 32'(got_bits[i]), 32'(exp_bits[i]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        src = '{8'hA5, 8'h3C, 8'h0F};
        exp_bits = 20'hF3CA5;
        tbl[0] = '{"run_stop",   1'b0, 1'b1, 1'b0, 5'b00000};
        tbl[1] = '{"idle_stop",  1'b0, 1'b1, 1'b0, 5'b00000};
        tbl[2] = '{"idle_rdy",   1'b0, 1'b0, 1'b1, 5'b00000};
        tbl[3] = '{"idle_start", 1'b1, 1'b0, 1'b0, 5'b10101};
        tbl[4] = '{"load_stop",  1'b0, 1'b1, 1'b0, 5'b10101};
        tbl[5] = '{"load_start", 1'b1, 1'b0, 1'b0, 5'b10101};
        tbl[6] = '{"load_rdy",   1'b0, 1'b0, 1'b1, 5'b10101};

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({cfg, run, busy, error, host_tready, cfg_tvalid}), 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_after_reset", 32'({cfg, run, busy, error}), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_load", 32'({cfg, run, busy, error}), 32'b1010);

        // Basic load: 3 bytes, 23 cycles from LOAD entry to the last bit.
        run_load(4'b1111, LEN, cyc);
        chk("load_cycles", 32'(cyc), 32'd23);
        chk("host_bytes", 32'(hs), 32'd3);
        check_bits("basic");
        chk("wait_state", 32'({cfg, run, busy, cfg_tvalid, host_tready}), 32'b10100);
        repeat (3) step();
        chk("wait_3", 32'({cfg, run, busy, error}), 32'b1010);
        cfg_ready = 1'b1;
        step();
        cfg_ready = 1'b0;
        chk("run_entry", 32'({cfg, run, busy, error}), 32'b0100);

        foreach (tbl[i]) begin
            start = tbl[i].start;
            stop = tbl[i].stop;
            cfg_ready = tbl[i].rdy;
            step();
            start = 1'b0;
            stop = 1'b0;
            cfg_ready = 1'b0;
            chk(tbl[i].name, 32'({cfg, run, busy, error, host_tready}), 32'(tbl[i].exp));
        end

        // Backpressure from the table's LOAD state.
        run_load(4'b1001, LEN, cyc);
        chk("bp_host_bytes", 32'(hs), 32'd3);
        check_bits("bp");

        // Timeout: error lands exactly TO cycles after WAIT_READY entry.
        n = 0;
        while (!error && n < 40) begin
            step();
            n++;
        end
        chk("timeout_cycles", 32'(n), 32'(TO));
        chk("err_out", 32'({cfg, run, busy, error}), 32'b0001);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("err_stop_ignored", 32'({cfg, run, busy, error}), 32'b0001);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("err_start", 32'({cfg, run, busy, error}), 32'b1010);

        // cfg_ready on the final WAIT_READY cycle beats the timeout.
        run_load(4'b1111, LEN, cyc);
        repeat (TO - 1) step();
        chk("pre_race", 32'({cfg, run, busy, error}), 32'b1010);
        cfg_ready = 1'b1;
        step();
        cfg_ready = 1'b0;
        chk("race", 32'({cfg, run, busy, error}), 32'b0100);

        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        chk("start_stop", 32'({cfg, run, busy, error, host_tready}), 32'b10101);

        // Async reset in the middle of LOAD.
        run_load(4'b1111, 10, cyc);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", 32'({cfg, run, busy, cfg_tvalid, host_tready}), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        run_load(4'b1111, LEN, cyc);
        chk("rst_load_cycles", 32'(cyc), 32'd23);
        check_bits("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
